icache_set_assoc: RTL and testbench
===================================

// Module: icache_set_assoc
// PURPOSE
//  N-way set-associative instruction cache with an integrated miss FSM. It replaces the
//  fixed direct-mapped icache between IFetch and the memory controller. Hits are answered
//  in 1 cycle. Misses fetch a whole block as 32-bit beats, fill the victim way and return
//  the word. It also supports a fetch cancel on redirect and full invalidation on fence.i.
// PARAMETERS
//  WAYS        2   associativity; power of 2, 1..8
//  SETS        16  number of sets; power of 2
//  BLOCK_WORDS 4   32-bit words per block; power of 2, >=2
//  ADDR_WIDTH  17  significant address bits; tag = ADDR_WIDTH-log2(SETS)-log2(BLOCK_WORDS)-2
// PORTS
//  clk_in         in   1   clock, rising edge
//  rst_in         in   1   reset, asynchronous, active-high
//  rdy_in         in   1   global ready; when low, all state and outputs freeze
//  req_valid      in   1   IFetch requests the word at req_addr
//  req_addr       in   32  byte address; bits [1:0] ignored
//  req_ready      out  1   cache accepts a request this cycle
//  resp_valid     out  1   1-cycle pulse: resp_inst is valid
//  resp_inst      out  32  instruction word
//  cancel         in   1   redirect: drop the outstanding response
//  invalidate_all in   1   fence.i: clear all valid bits
//  mem_req        out  1   block fetch request, held until the last beat
//  mem_addr       out  32  block-aligned byte address of the fetch
//  mem_beat_valid in   1   one 32-bit beat delivered, in ascending word order
//  mem_beat_data  in   32  beat payload
// BEHAVIOUR
//  Reset: all valid bits=0, replacement pointers=0, state=IDLE.
//    Outputs after reset: req_ready=1, resp_valid=0, resp_inst=0, mem_req=0, mem_addr=0.
//  rdy_in=0: nothing updates, including beat capture.
//    Memory does not send beats while rdy_in=0.
//  Address split: word offset = addr[log2(BW)+1:2], index above it, tag above index,
//    up to bit ADDR_WIDTH-1.
//  FSM states: IDLE, MISS, FILL.
//  IDLE: req_ready = !invalidate_all.
//    Accept occurs when req_valid && req_ready; all ways are compared combinationally.
//    Hit: resp_valid=1 and resp_inst=word on the next cycle; stay IDLE.
//      Back-to-back hits give 1 resp per cycle.
//    Miss: latch addr, clear beat counter, go to MISS. mem_req=1 from the next cycle.
//  MISS: req_ready=0. mem_req=1; mem_addr = latched addr with low log2(BW)+2 bits zeroed.
//    Each mem_beat_valid writes line_buf[cnt] and increments cnt.
//    When the beat with cnt==BW-1 arrives: mem_req drops on the next cycle and state goes to FILL.
//  FILL (1 cycle): req_ready=0.
//    Victim = lowest-numbered invalid way in the set; if all ways are valid, ptr[set].
//    Write tag, data and valid=1 to the victim. If the victim came from ptr, ptr[set]++ mod WAYS.
//    resp_valid=1, resp_inst=line_buf[offset] in the same cycle, unless the cancel flag is set.
//    Next state is IDLE.
//  Miss latency: accept at cycle T, mem_req from T+1, last beat at cycle L, resp at L+1.
//  cancel:
//    IDLE: suppresses the resp_valid that would be generated next cycle.
//      A request accepted in the same cycle is dropped entirely, with no miss started.
//    MISS: sets a sticky cancel flag. The refill still completes and the line is written;
//      the response is suppressed. The flag is cleared on entering IDLE.
//  invalidate_all:
//    IDLE: clears all valid bits on the next edge; ptrs unchanged; the request is not accepted.
//    MISS/FILL: recorded as pending; applied on the cycle after FILL. The filled line is also invalidated.
//  Replacement: the pointer advances only on a valid-way eviction; hits do not touch it.
//  Beats arriving in IDLE or FILL are ignored (protocol error, assertion in bench).
//  Reset asserted mid-MISS: FSM goes to IDLE immediately; mem_req drops asynchronously;
//    line_buf contents are discarded.
// TESTING
//  1. Cold miss addr 0x0100, WAYS=2, BW=4: mem_req with mem_addr=0x0100, 4 beats A0..A3.
//     -> resp_inst=A0 the cycle after the A3 beat; re-read 0x0104 -> A1 one cycle after accept.
//  2. Three blocks in one set (0x0000, 0x0400, 0x0800 with SETS=16, BW=4).
//     -> the third fill evicts way 0 (ptr 0->1); re-reading 0x0000 misses, 0x0400 hits.
//  3. cancel while in MISS for 0x0200 -> no resp_valid; a later request to 0x0200 hits in 1 cycle.
//  4. invalidate_all during MISS -> fill completes, no early clear.
//     The next request to the filled address misses (mem_req re-asserted).
//  5. rdy_in low for 5 cycles mid-MISS after 2 beats -> beat counter holds at 2.
//     Remaining 2 beats accepted after release; resp is correct.
//  6. rst_in pulse asserted between clock edges during MISS -> mem_req=0 and req_ready=1 immediately.
//     Every address misses afterwards.

Source files
------------

// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache with an integrated block-refill FSM (IDLE/MISS/FILL).
// Hits respond one cycle after accept; misses fetch a block as 32-bit beats and fill a victim way.
module icache_set_assoc #(
  parameter int WAYS        = 2,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  input  logic        cancel,
  input  logic        invalidate_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_beat_valid,
  input  logic [31:0] mem_beat_data,
  output logic [1:0]  state_dbg
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int LO    = OFF_W + 2;
  localparam int TAG_W = ADDR_WIDTH - IDX_W - LO;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MISS = 2'd1, S_FILL = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SETS-1:0]        valid_q  [WAYS];
  logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
  logic [31:0]            data_mem [WAYS][SETS][BLOCK_WORDS];
  logic [WAY_W-1:0]       ptr_q    [SETS];
  logic [31:0]            line_buf [BLOCK_WORDS];
  logic [OFF_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  miss_addr_q;
  logic                   cancel_q, inv_pend_q, resp_valid_q;
  logic [31:0]            resp_inst_q;

  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [OFF_W-1:0] req_off, miss_off;
  logic             hit, accept, last_beat, victim_from_ptr;
  logic [31:0]      hit_word, fill_word;
  logic [WAY_W-1:0] victim;
  logic             unused_addr_bits;

  assign req_tag  = req_addr[ADDR_WIDTH-1:LO+IDX_W];
  assign req_idx  = req_addr[LO +: IDX_W];
  assign req_off  = req_addr[2 +: OFF_W];
  assign miss_tag = miss_addr_q[ADDR_WIDTH-1:LO+IDX_W];
  assign miss_idx = miss_addr_q[LO +: IDX_W];
  assign miss_off = miss_addr_q[2 +: OFF_W];
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH], req_addr[1:0], miss_addr_q[1:0]};

  // Handshake: a request is taken on a rising edge with req_valid && req_ready && rdy_in;
  // resp_valid is a one-cycle pulse and the requester must always be able to take it.
  assign req_ready = (state_q == S_IDLE) && !invalidate_all && !inv_pend_q;
  assign accept    = rdy_in && req_valid && req_ready;
  assign last_beat = mem_beat_valid && (cnt_q == OFF_W'(BLOCK_WORDS - 1));
  assign fill_word = (miss_off == OFF_W'(BLOCK_WORDS - 1)) ? mem_beat_data : line_buf[miss_off];

  assign mem_req    = (state_q == S_MISS);
  assign mem_addr   = 32'({miss_addr_q[ADDR_WIDTH-1:LO], {LO{1'b0}}});
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign state_dbg  = state_q;

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_word = data_mem[w][req_idx][req_off];
      end
    end
  end

  // Lowest-numbered invalid way wins; the round-robin pointer is used only when the set is full.
  always_comb begin
    victim          = ptr_q[miss_idx];
    victim_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][miss_idx]) begin
        victim          = WAY_W'(w);
        victim_from_ptr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE:  if (accept && !cancel && !hit) state_d = S_MISS;
        S_MISS:  if (last_beat) state_d = S_FILL;
        S_FILL:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      cnt_q        <= '0;
      miss_addr_q  <= '0;
      cancel_q     <= 1'b0;
      inv_pend_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
    end else if (rdy_in) begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inv_pend_q || invalidate_all) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            inv_pend_q <= 1'b0;
          end else if (accept && !cancel) begin
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_inst_q  <= hit_word;
            end else begin
              miss_addr_q <= req_addr[ADDR_WIDTH-1:0];
              cnt_q       <= '0;
            end
          end
        end
        S_MISS: begin
          if (cancel)         cancel_q   <= 1'b1;
          if (invalidate_all) inv_pend_q <= 1'b1;
          if (mem_beat_valid) cnt_q <= cnt_q + 1'b1;
          // The response is registered off the last beat so it appears during the FILL cycle.
          if (last_beat) begin
            resp_valid_q <= !(cancel_q || cancel);
            resp_inst_q  <= fill_word;
          end
        end
        S_FILL: begin
          valid_q[victim][miss_idx] <= 1'b1;
          if (victim_from_ptr)
            ptr_q[miss_idx] <= (ptr_q[miss_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[miss_idx] + 1'b1;
          if (invalidate_all) inv_pend_q <= 1'b1;
          cancel_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (state_q == S_MISS && mem_beat_valid) line_buf[cnt_q] <= mem_beat_data;
      if (state_q == S_FILL) begin
        tag_mem[victim][miss_idx] <= miss_tag;
        for (int b = 0; b < BLOCK_WORDS; b++) data_mem[victim][miss_idx][b] <= line_buf[b];
      end
    end
  end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: a set/way/pointer model decides hit or miss,
// and one negedge process checks resp and mem_req/mem_addr every cycle.
module tb_icache_set_assoc;

  localparam int WAYS = 2;
  localparam int SETS = 16;
  localparam int BW   = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        cancel = 1'b0;
  logic        invalidate_all = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_beat_valid = 1'b0;
  logic [31:0] mem_beat_data = '0;
  logic [1:0]  state_dbg;

  icache_set_assoc #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW), .ADDR_WIDTH(17)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .cancel(cancel), .invalidate_all(invalidate_all),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_ptr   [SETS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {a[31:2], 2'b00};
  endfunction
  function automatic int set_of(input logic [31:0] a);
    return int'(a[7:4]);
  endfunction
  function automatic int tag_of(input logic [31:0] a);
    return int'(a[16:8]);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s, v;
    s = set_of(a);
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(a);
  endtask

  task automatic model_clear(input bit with_ptrs);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      if (with_ptrs) m_ptr[s] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        exp_mem_req  = 1'b0;
  logic [31:0] exp_mem_addr = '0;
  logic [31:0] last_resp    = '0;

  always @(negedge clk) begin
    bit due;
    due = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    check("resp_valid", {31'd0, resp_valid}, {31'd0, due});
    if (due) begin
      check("resp_inst", resp_inst, exp_q[0]);
      last_resp = resp_inst;
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    check("mem_req", {31'd0, mem_req}, {31'd0, exp_mem_req});
    if (exp_mem_req) check("mem_addr", mem_addr, exp_mem_addr);
  end

  // Memory must never deliver a beat the cache did not ask for.
  always @(posedge clk) begin
    if (mem_beat_valid && rdy_in) check("beat_only_in_miss", {31'd0, mem_req}, 32'd1);
  end

  // ---------------- driver tasks (all start/end 1 time unit after a rising edge) ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // mode: 0 plain, 1 cancel during miss, 2 invalidate_all during miss,
  //       3 rdy_in low for 5 cycles after 2 beats, 4 cancel in the accept cycle
  task automatic access(input logic [31:0] a, input int mode, output bit was_miss);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    if (mode == 4) cancel = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cancel    = 1'b0;
    was_miss  = !model_hit(a);
    if (mode == 4) begin
      was_miss = 1'b0;
    end else if (!was_miss) begin
      exp_cyc_q.push_back(cyc);
      exp_q.push_back(mem_word(a));
    end else begin
      exp_mem_req  = 1'b1;
      exp_mem_addr = base;
      for (int b = 0; b < BW; b++) begin
        if (b == 1) begin @(posedge clk); #1; end
        if (b == 2 && mode == 3) begin
          rdy_in = 1'b0;
          repeat (5) begin @(posedge clk); #1; end
          rdy_in = 1'b1;
        end
        mem_beat_valid = 1'b1;
        mem_beat_data  = mem_word(base + 32'(4 * b));
        if (b == 1 && mode == 1) cancel = 1'b1;
        if (b == 1 && mode == 2) invalidate_all = 1'b1;
        @(posedge clk); #1;
        mem_beat_valid = 1'b0;
        cancel         = 1'b0;
        invalidate_all = 1'b0;
      end
      exp_mem_req = 1'b0;
      if (mode != 1) begin
        exp_cyc_q.push_back(cyc);
        exp_q.push_back(mem_word(a));
      end
      model_fill(a);
      if (mode == 2) model_clear(1'b0);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit m;
    model_clear(1'b1);
    #2 rst_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_inst",  resp_inst,           32'd0);
    check("rst_mem_req",    {31'd0, mem_req},    32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);

    // cold miss then re-read of a neighbouring word
    access(32'h0100, 0, m);  check("t1_cold_miss", {31'd0, m}, 32'd1);
    check("t1_word_a0", last_resp, 32'hA000_0100);
    access(32'h0104, 0, m);  check("t1_reread_hit", {31'd0, m}, 32'd0);
    check("t1_word_a1", last_resp, 32'hA000_0104);

    // back-to-back hits, one response per cycle
    wait_ready();
    for (int i = 0; i < BW; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0100 + 32'(4 * i);
      @(posedge clk); #1;
      exp_cyc_q.push_back(cyc);
      exp_q.push_back(mem_word(req_addr));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_last_word", last_resp, 32'hA000_010C);

    // cancel in the accept cycle: hit dropped, miss never started
    access(32'h0108, 4, m);
    access(32'h0700, 4, m);
    access(32'h0700, 0, m);  check("cancel_idle_no_fill", {31'd0, m}, 32'd1);

    // invalidate_all in IDLE blocks the request and clears everything
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0100;
    invalidate_all = 1'b1;
    #1 check("inv_idle_not_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    invalidate_all = 1'b0;
    model_clear(1'b0);

    // three blocks in set 0: third fill evicts way 0
    access(32'h0000, 0, m);  check("t2_fill0_miss", {31'd0, m}, 32'd1);
    access(32'h0400, 0, m);  check("t2_fill1_miss", {31'd0, m}, 32'd1);
    access(32'h0800, 0, m);  check("t2_fill2_miss", {31'd0, m}, 32'd1);
    check("t2_model_ptr", 32'(m_ptr[0]), 32'd1);
    access(32'h0400, 0, m);  check("t2_0400_hit", {31'd0, m}, 32'd0);
    access(32'h0000, 0, m);  check("t2_0000_miss", {31'd0, m}, 32'd1);

    // cancel during MISS: no response, line still filled
    access(32'h0200, 1, m);  check("t3_miss", {31'd0, m}, 32'd1);
    access(32'h0200, 0, m);  check("t3_hit_after_cancel", {31'd0, m}, 32'd0);
    check("t3_word", last_resp, 32'hA000_0200);

    // invalidate_all during MISS: fill completes, then everything is cleared
    access(32'h0320, 2, m);  check("t4_miss", {31'd0, m}, 32'd1);
    check("t4_word", last_resp, 32'hA000_0320);
    access(32'h0320, 0, m);  check("t4_refetch_miss", {31'd0, m}, 32'd1);

    // rdy_in low for 5 cycles after two beats
    access(32'h0518, 3, m);  check("t5_miss", {31'd0, m}, 32'd1);
    check("t5_word", last_resp, 32'hA000_0518);

    // asynchronous reset in the middle of a miss
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0600;
    @(posedge clk); #1;
    req_valid      = 1'b0;
    exp_mem_req    = 1'b1;
    exp_mem_addr   = 32'h0600;
    mem_beat_valid = 1'b1;
    mem_beat_data  = mem_word(32'h0600);
    @(posedge clk); #1;
    mem_beat_valid = 1'b0;
    #2 rst_in = 1'b1;
    exp_mem_req = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    model_clear(1'b1);
    #1;
    check("t6_mem_req_async",   {31'd0, mem_req},   32'd0);
    check("t6_req_ready_async", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 rst_in = 1'b0;
    access(32'h0100, 0, m);  check("t6_0100_miss", {31'd0, m}, 32'd1);
    access(32'h0600, 0, m);  check("t6_0600_miss", {31'd0, m}, 32'd1);
    check("t6_word", last_resp, 32'hA000_0600);

    repeat (3) @(posedge clk);
    #1 check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
